// File: rtl/mem_addr_pkg.sv
// Shared types for the memory-stage address unit: access modes and sequencer states.
package mem_addr_pkg;

  typedef enum logic [1:0] {
    MODE_ALU  = 2'd0,
    MODE_SP   = 2'd1,
    MODE_PUSH = 2'd2,
    MODE_POP  = 2'd3
  } op_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_addr_unit_sp_reg.sv
// Stack-pointer register: reset value, direct load, and +/- SP_STEP on commit strobes.
module sp_reg #(
  parameter int          ADDR_W   = 32,
  parameter int          SP_STEP  = 4,
  parameter logic [31:0] SP_RESET = 32'h0000_FFFC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [ADDR_W-1:0] sp_o
);

  localparam logic [ADDR_W-1:0] RST_V  = ADDR_W'(SP_RESET);
  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(SP_STEP);

  logic [ADDR_W-1:0] sp_q, sp_d;

  // Arithmetic wraps modulo 2^ADDR_W by construction.
  always_comb begin
    sp_d = sp_q;
    if (load_i)     sp_d = wdata_i;
    else if (inc_i) sp_d = sp_q + STEP_V;
    else if (dec_i) sp_d = sp_q - STEP_V;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= RST_V;
    else        sp_q <= sp_d;
  end

  assign sp_o = sp_q;

endmodule

// File: rtl/mem_addr_unit.sv
// Memory-stage address generator and access sequencer (IDLE -> REQ -> DONE).
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses skip the request and pulse fault with done.
module mem_addr_unit
  import mem_addr_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          SP_STEP  = 4,
  parameter logic [31:0] SP_RESET = 32'h0000_FFFC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [1:0]        op_mode,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic              sp_load,
  input  logic [ADDR_W-1:0] sp_wdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] sp_out,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        dbg_state
);

  // Handshake: mem_req rises the cycle after acceptance and holds with a
  // stable mem_addr until mem_ack is seen high on a rising edge; the
  // pipeline holds op_valid until the unit leaves IDLE.

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(SP_STEP);

  state_e            state_q, state_d;
  op_mode_e          mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] calc_addr;
  logic              misaligned;
  logic              sp_ld, sp_inc, sp_dec;

  sp_reg #(
    .ADDR_W  (ADDR_W),
    .SP_STEP (SP_STEP),
    .SP_RESET(SP_RESET)
  ) u_sp_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (sp_ld),
    .wdata_i(sp_wdata),
    .inc_i  (sp_inc),
    .dec_i  (sp_dec),
    .sp_o   (sp_out)
  );

  always_comb begin
    calc_addr = alu_addr;
    case (op_mode_e'(op_mode))
      MODE_ALU:  calc_addr = alu_addr;
      MODE_SP:   calc_addr = sp_out;
      MODE_PUSH: calc_addr = sp_out - STEP_V;
      MODE_POP:  calc_addr = sp_out;
      default:   calc_addr = alu_addr;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = STEP_V - 1'b1;
  assign misaligned = |(calc_addr & ALIGN_MASK);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    sp_ld   = 1'b0;
    sp_inc  = 1'b0;
    sp_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sp_load) begin
          sp_ld = 1'b1;
        end else if (op_valid) begin
          mode_d = op_mode_e'(op_mode);
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            fault_d = 1'b0;
            addr_d  = calc_addr;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          sp_inc  = (mode_q == MODE_POP);
          sp_dec  = (mode_q == MODE_PUSH);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        fault_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ALU;
      addr_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req   = (state_q == ST_REQ);
  assign mem_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign fault     = (state_q == ST_DONE) && fault_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_addr_unit.sv
// Bench for mem_addr_unit: directed table, hand sequences for load/wrap/reset, random ops vs. a model.
module tb_mem_addr_unit;

  localparam int          STEP  = 4;
  localparam logic [31:0] SP_RV = 32'h0000_FFFC;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic        clk, rst_n;
  logic        op_valid, sp_load, mem_ack;
  logic [1:0]  op_mode;
  logic [31:0] alu_addr, sp_wdata;
  logic        mem_req, busy, done, fault;
  logic [31:0] mem_addr, sp_out;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sp_m;

  mem_addr_unit #(.ADDR_W(32), .SP_STEP(STEP), .SP_RESET(SP_RV)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_mode(op_mode),
    .alu_addr(alu_addr), .sp_load(sp_load), .sp_wdata(sp_wdata),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr),
    .sp_out(sp_out), .busy(busy), .done(done), .fault(fault),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  mode;
    logic [31:0] alu;
    int          waits;
    logic [31:0] e_addr;
    logic [31:0] e_sp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: what an access should do, from the mode rules and the current SP.
  function automatic void model(input logic [1:0] m, input logic [31:0] a,
                                output logic [31:0] e_addr, output logic [31:0] e_sp,
                                output logic e_fault);
    case (m)
      2'd0:    e_addr = a;
      2'd1:    e_addr = sp_m;
      2'd2:    e_addr = sp_m - STEP;
      default: e_addr = sp_m;
    endcase
    e_fault = ALIGN_ON && ((e_addr % STEP) != 0);
    if (e_fault)      e_sp = sp_m;
    else if (m == 2)  e_sp = sp_m - STEP;
    else if (m == 3)  e_sp = sp_m + STEP;
    else              e_sp = sp_m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_op(input string nm, input logic [1:0] mode, input logic [31:0] alu,
                       input int waits, input logic [31:0] e_addr, input logic [31:0] e_sp,
                       input logic e_fault);
    @(negedge clk);
    check({nm, ".idle"}, {31'd0, busy}, 32'd0);
    op_valid = 1'b1; op_mode = mode; alu_addr = alu;
    @(negedge clk);
    op_valid = 1'b0;
    if (e_fault) begin
      check({nm, ".f_req"},   {31'd0, mem_req}, 32'd0);
      check({nm, ".f_done"},  {31'd0, done},    32'd1);
      check({nm, ".f_fault"}, {31'd0, fault},   32'd1);
      check({nm, ".f_sp"},    sp_out,           e_sp);
    end else begin
      exp_q.push_back(e_addr);
      check({nm, ".req"}, {31'd0, mem_req}, 32'd1);
      check({nm, ".addr"}, mem_addr, exp_q.pop_front());
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        check({nm, ".wreq"},  {31'd0, mem_req}, 32'd1);
        check({nm, ".waddr"}, mem_addr,         e_addr);
        check({nm, ".wsp"},   sp_out,           sp_m);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check({nm, ".done"},  {31'd0, done},    32'd1);
      check({nm, ".fault"}, {31'd0, fault},   32'd0);
      check({nm, ".dreq"},  {31'd0, mem_req}, 32'd0);
      check({nm, ".sp"},    sp_out,           e_sp);
    end
    @(negedge clk);
    check({nm, ".pulse"}, {31'd0, done}, 32'd0);
    check({nm, ".free"},  {31'd0, busy}, 32'd0);
    sp_m = e_sp;
  endtask

  task automatic load_sp(input logic [31:0] v);
    @(negedge clk);
    sp_load = 1'b1; sp_wdata = v;
    @(negedge clk);
    sp_load = 1'b0;
    check("load.sp", sp_out, v);
    sp_m = v;
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] ea, es, a;
    logic        ef;
    logic [1:0]  m;

    rst_n = 1'b0; op_valid = 1'b0; op_mode = 2'd0; alu_addr = '0;
    sp_load = 1'b0; sp_wdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.sp",    sp_out,             SP_RV);
    check("rst.req",   {31'd0, mem_req},   32'd0);
    check("rst.busy",  {31'd0, busy},      32'd0);
    check("rst.done",  {31'd0, done},      32'd0);
    check("rst.fault", {31'd0, fault},     32'd0);
    check("rst.addr",  mem_addr,           32'd0);
    rst_n = 1'b1;
    sp_m = SP_RV;

    // ---------------- directed table ----------------
    vecs[0] = '{"push_w2", 2'd2, 32'h0,         2, 32'hFFF8,      32'hFFF8};
    vecs[1] = '{"pop_w0",  2'd3, 32'h0,         0, 32'hFFF8,      32'hFFFC};
    vecs[2] = '{"sp_w1",   2'd1, 32'h0,         1, 32'hFFFC,      32'hFFFC};
    vecs[3] = '{"alu_w0",  2'd0, 32'h1234_5670, 0, 32'h1234_5670, 32'hFFFC};
    vecs[4] = '{"push_a",  2'd2, 32'h0,         0, 32'hFFF8,      32'hFFF8};
    vecs[5] = '{"push_b",  2'd2, 32'h0,         3, 32'hFFF4,      32'hFFF4};
    vecs[6] = '{"sp_b",    2'd1, 32'hDEAD_0000, 0, 32'hFFF4,      32'hFFF4};
    vecs[7] = '{"pop_a",   2'd3, 32'h0,         1, 32'hFFF4,      32'hFFF8};
    vecs[8] = '{"pop_b",   2'd3, 32'h0,         0, 32'hFFF8,      32'hFFFC};
    foreach (vecs[i])
      do_op(vecs[i].nm, vecs[i].mode, vecs[i].alu, vecs[i].waits,
            vecs[i].e_addr, vecs[i].e_sp, 1'b0);

    // Misaligned ALU address: faults only with the alignment check built in.
    do_op("alu_1002", 2'd0, 32'h1002, 0, 32'h1002, 32'hFFFC, ALIGN_ON);

    // sp_load wins over op_valid in IDLE; the held op is taken next cycle and wraps.
    @(negedge clk);
    sp_load = 1'b1; sp_wdata = 32'h0; op_valid = 1'b1; op_mode = 2'd2;
    @(negedge clk);
    sp_load = 1'b0;
    check("ldpri.sp",   sp_out,          32'h0);
    check("ldpri.busy", {31'd0, busy},   32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    check("wrap.req",  {31'd0, mem_req}, 32'd1);
    check("wrap.addr", mem_addr,         32'hFFFF_FFFC);
    // sp_load during REQ must be ignored.
    sp_load = 1'b1; sp_wdata = 32'h1230;
    @(negedge clk);
    sp_load = 1'b0;
    check("ldreq.sp",  sp_out,           32'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("wrap.done", {31'd0, done},    32'd1);
    check("wrap.sp",   sp_out,           32'hFFFF_FFFC);
    @(negedge clk);
    sp_m = 32'hFFFF_FFFC;
    do_op("pop_wrap", 2'd3, 32'h0, 0, 32'hFFFF_FFFC, 32'h0, 1'b0);

    // mem_ack while IDLE does nothing.
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("ackidle.busy", {31'd0, busy}, 32'd0);
    check("ackidle.done", {31'd0, done}, 32'd0);
    check("ackidle.sp",   sp_out,        32'h0);

    // Reset in the middle of a PUSH request.
    load_sp(32'h0000_8000);
    @(negedge clk);
    op_valid = 1'b1; op_mode = 2'd2;
    @(negedge clk);
    op_valid = 1'b0;
    check("rmid.req0", {31'd0, mem_req}, 32'd1);
    check("rmid.addr0", mem_addr, 32'h0000_7FFC);
    mem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rmid.req",  {31'd0, mem_req}, 32'd0);
    check("rmid.busy", {31'd0, busy},    32'd0);
    check("rmid.sp",   sp_out,           SP_RV);
    check("rmid.addr", mem_addr,         32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rmid.done", {31'd0, done}, 32'd0);
    check("rmid.sp2",  sp_out,        SP_RV);
    sp_m = SP_RV;

    // ---------------- random ops against the model ----------------
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0)
        load_sp($urandom() & 32'hFFFF_FFFC);
      m = 2'($urandom_range(0, 3));
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      model(m, a, ea, es, ef);
      do_op($sformatf("rnd%0d", n), m, a, $urandom_range(0, 3), ea, es, ef);
    end

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard leftover got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_addr_unit.md
# mem_addr_unit

Memory-stage address generator and access sequencer for the CPU pipeline: the parametrised successor of the combinational ALU/stack-pointer address select. It owns the stack pointer, supports plain ALU addressing, SP-relative access, push (pre-decrement) and pop (post-increment), and drives a registered address with a request/acknowledge handshake toward the memory controller. It stalls the pipeline while an access is in flight.

## Interface
Parameters:
- ADDR_W, 32, address and stack-pointer width
- SP_STEP, 4, bytes per push/pop; power of two ≥1
- SP_RESET, 32'h0000_FFFC, stack-pointer value after reset (truncated to ADDR_W)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  pipeline presents an access; held until accepted
- op_mode  in  2  0=ALU, 1=SP, 2=PUSH, 3=POP
- alu_addr  in  ADDR_W  ALU-computed address (used in ALU mode)
- sp_load  in  1  load stack pointer from sp_wdata
- sp_wdata  in  ADDR_W  new stack-pointer value
- mem_ack  in  1  controller accepted the current request
- mem_req  out  1  request valid to memory controller
- mem_addr  out  ADDR_W  registered request address
- sp_out  out  ADDR_W  current stack pointer
- busy  out  1  access in flight; pipeline stall
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle misalignment pulse (with done)

## Operation
- FSM states IDLE, REQ, DONE.
- IDLE: if sp_load, sp_out <= sp_wdata, op not accepted this cycle (load has priority). Else if op_valid, op accepted: address computed, mem_addr/mode latched, go REQ.
- Address: ALU → alu_addr; SP → sp_out; PUSH → sp_out − SP_STEP; POP → sp_out.
- REQ: mem_req=1, mem_addr stable. On mem_ack: PUSH commits sp_out −= SP_STEP, POP commits sp_out += SP_STEP; go DONE.
- DONE: done=1 for one cycle, return to IDLE. New op not accepted in DONE.
- busy = (state != IDLE).
- SP arithmetic modulo 2^ADDR_W; wrap-around silent (0 − 4 → all-ones−3).
- sp_load outside IDLE ignored.
- Reset (asynchronous, any state): state IDLE, mem_req=0, mem_addr=0, busy=0, done=0, fault=0, sp_out=SP_RESET. In-flight access abandoned, no SP update.

## Timing
- Op accepted at edge N (op_valid in IDLE) → mem_req and mem_addr valid from N+1.
- mem_ack sampled while mem_req=1; ack in first REQ cycle → done at N+2; minimum 3 cycles op-to-op.
- mem_req held, mem_addr unchanged through any number of ack-less cycles.
- SP update visible on sp_out the cycle after ack (same cycle done asserts).
- mem_ack outside REQ ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined: at acceptance, if computed address bits [log2(SP_STEP)−1:0] ≠ 0 (SP_STEP>1), no request issued, no SP update; FSM goes IDLE→DONE directly, done=1 and fault=1 in that cycle.
- Undefined: no check, fault tied 0, every accepted op issues a request.

## Structure
- Package mem_addr_pkg: op_mode enum (MODE_ALU, MODE_SP, MODE_PUSH, MODE_POP), state enum (ST_IDLE, ST_REQ, ST_DONE).
- Sub-module sp_reg: holds stack pointer, reset value, load, increment/decrement by SP_STEP on commit strobes.

## Test plan
- Reset with SP_RESET=0xFFFC → sp_out=0xFFFC, mem_req=0, busy=0, done=0.
- PUSH, ack after 2 wait cycles → mem_addr=0xFFF8 held 3 REQ cycles; sp_out=0xFFF8 with done.
- POP from sp=0xFFF8, immediate ack → mem_addr=0xFFF8, done at op+2, sp_out=0xFFFC.
- sp_load=1 with op_valid=1 in IDLE, sp_wdata=0 → sp_out=0, op accepted next cycle; then PUSH → mem_addr=0xFFFF_FFFC (wrap).
- With MEM_ALIGN_CHECK_EN, ALU op alu_addr=0x1002 → no mem_req, done=fault=1 one cycle after acceptance; without it → mem_addr=0x1002 requested.
- rst_n asserted mid-REQ after PUSH → mem_req drops immediately, sp_out=SP_RESET, no done.
